// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order decoupling FIFO between decode and the four
// reservation stations (00 ALU, 01 load/store, 10 branch/JAL/JALR, 11 LUI/AUIPC).
// The head entry issues only when its station and the ROB can both accept it.
// A flush empties the queue in one cycle.
// Optional feature: define DISPATCH_STATS_EN to add the saturating
// stall_cycles counter and its output port.
module dispatch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  logic [92:0] enq_payload,
    input  logic [1:0]  enq_rs_station,
    input  logic [3:0]  rs_full,
    input  logic        rob_full,
    output logic        disp_valid,
    output logic        disp_fire,
    output logic [3:0]  disp_rs_sel,
    output logic [92:0] disp_payload,
    output logic [1:0]  disp_rs_station
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [92:0]   payload_mem [DEPTH];
    logic [1:0]    station_mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    logic          do_enq;

    // A full queue refuses input even if the head leaves this cycle.
    assign enq_ready       = (count != FULL_COUNT);
    assign disp_valid      = (count != '0);
    assign do_enq          = enq_valid && enq_ready && !flush;
    assign disp_payload    = payload_mem[rptr];
    assign disp_rs_station = station_mem[rptr];

    // Issue decision and one-hot station write enable for the head entry.
    always_comb begin
        disp_fire   = disp_valid && !rs_full[disp_rs_station] && !rob_full && !flush;
        disp_rs_sel = 4'b0000;
        if (disp_fire) begin
            disp_rs_sel = 4'b0001 << disp_rs_station;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            payload_mem[wptr] <= enq_payload;
            station_mem[wptr] <= enq_rs_station;
        end
    end

    // Pointer and occupancy update; flush squashes everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                wptr <= wptr + AW'(1);
            end
            if (disp_fire) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_enq, disp_fire})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    // Saturating count of cycles where a valid head could not issue; survives flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (disp_valid && !disp_fire && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: stimulus pushes the expected issue
// order, a negedge monitor pops and compares on every disp_fire.
module tb_dispatch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [92:0] enq_payload;
    logic [1:0]  enq_rs_station;
    logic [3:0]  rs_full;
    logic        rob_full;
    logic        disp_valid;
    logic        disp_fire;
    logic [3:0]  disp_rs_sel;
    logic [92:0] disp_payload;
    logic [1:0]  disp_rs_station;
`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    // {station, payload} in expected issue order.
    logic [94:0] exp_q [$];
    logic [94:0] mon_e;

    dispatch_queue #(.DEPTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_payload     (enq_payload),
        .enq_rs_station  (enq_rs_station),
        .rs_full         (rs_full),
        .rob_full        (rob_full),
        .disp_valid      (disp_valid),
        .disp_fire       (disp_fire),
        .disp_rs_sel     (disp_rs_sel),
        .disp_payload    (disp_payload),
        .disp_rs_station (disp_rs_station)
`ifdef DISPATCH_STATS_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [92:0] mk(input logic [31:0] pc);
        return {pc, ~pc, pc[4:0], pc[9:5], pc[14:10], pc[2:0], pc[10:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an enqueue for this cycle and record it as expected.
    task automatic enq(input logic [31:0] pc, input logic [1:0] st);
        enq_valid      = 1'b1;
        enq_payload    = mk(pc);
        enq_rs_station = st;
        exp_q.push_back({st, mk(pc)});
    endtask

    task automatic idle();
        enq_valid = 1'b0;
    endtask

    // Monitor: every issued entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (disp_fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected_fire actual=%0h required=none", disp_payload);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_payload", 128'(disp_payload), 128'(mon_e[92:0]));
                check("mon_station", 128'(disp_rs_station), 128'(mon_e[94:93]));
                check("mon_rs_sel", 128'(disp_rs_sel), 128'(4'b0001 << mon_e[94:93]));
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_payload = '0;
        enq_rs_station = 2'd0; rs_full = 4'b0000; rob_full = 1'b0;
        #3;
        check("rst_disp_valid", 128'(disp_valid), 128'(0));
        check("rst_disp_fire", 128'(disp_fire), 128'(0));
        check("rst_rs_sel", 128'(disp_rs_sel), 128'(0));
        check("rst_enq_ready", 128'(enq_ready), 128'(1));
`ifdef DISPATCH_STATS_EN
        check("rst_stall", 128'(stall_cycles), 128'(0));
`endif
        step(); step();
        reset = 1'b0;

        // Single entry: visible and firing the cycle after enqueue.
        step(); enq(32'h100, 2'd0); #3;
        check("t1_empty_valid", 128'(disp_valid), 128'(0));
        step(); idle(); #3;
        check("t1_valid", 128'(disp_valid), 128'(1));
        check("t1_fire", 128'(disp_fire), 128'(1));
        check("t1_rs_sel", 128'(disp_rs_sel), 128'(4'b0001));
        check("t1_payload", 128'(disp_payload), 128'(mk(32'h100)));

        // Fill to full under rob_full, 9th ignored, then drain in order.
        step(); idle(); rob_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(); enq(32'h200 + 32'(i), 2'(i)); #3;
            check("t2_ready_fill", 128'(enq_ready), 128'(1));
        end
        step(); enq_valid = 1'b1; enq_payload = mk(32'h2FF); enq_rs_station = 2'd1; #3;
        check("t2_full_ready", 128'(enq_ready), 128'(0));
        step(); idle(); rob_full = 1'b0; #3;
        check("t2_still_full", 128'(enq_ready), 128'(0));
        for (int i = 0; i < 8; i++) begin
            if (i != 0) begin
                step(); #3;
            end
            check("t2_drain_fire", 128'(disp_fire), 128'(1));
        end
        step(); #3;
        check("t2_empty", 128'(disp_valid), 128'(0));

        // Blocked head on station 2; fresh reset gives a known stall count.
        reset = 1'b1; step(); reset = 1'b0;
        step(); enq(32'h300, 2'd2); rs_full = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step(); idle(); #3;
            check("t3_hold_valid", 128'(disp_valid), 128'(1));
            check("t3_hold_fire", 128'(disp_fire), 128'(0));
        end
        step(); rs_full = 4'b0000; #3;
`ifdef DISPATCH_STATS_EN
        check("t3_stall5", 128'(stall_cycles), 128'(5));
`endif
        check("t3_fire", 128'(disp_fire), 128'(1));
        check("t3_rs_sel", 128'(disp_rs_sel), 128'(4'b0100));

        // Count 3 with 10 cycles of simultaneous enq/fire; pointers wrap.
        step(); rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq(32'h400 + 32'(i), 2'(i + 1));
            step();
        end
        idle(); rob_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enq(32'h410 + 32'(i), 2'(3 - (i % 4))); #3;
            check("t4_fire", 128'(disp_fire), 128'(1));
            check("t4_ready", 128'(enq_ready), 128'(1));
            step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            #3;
            check("t4_tail_fire", 128'(disp_fire), 128'(1));
            step();
        end
        #3;
        check("t4_empty", 128'(disp_valid), 128'(0));

        // Flush with count 5 and a concurrent enqueue.
        step(); rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq(32'h500 + 32'(i), 2'd0);
            step();
        end
        rob_full = 1'b0; flush = 1'b1;
        enq_valid = 1'b1; enq_payload = mk(32'h5FF); enq_rs_station = 2'd0;
        exp_q.delete();
        #3;
        check("t5_flush_fire", 128'(disp_fire), 128'(0));
        step(); flush = 1'b0; idle(); #3;
        check("t5_valid", 128'(disp_valid), 128'(0));
        check("t5_ready", 128'(enq_ready), 128'(1));
        check("t5_fire_after", 128'(disp_fire), 128'(0));

        // Asynchronous reset mid-cycle with count 4.
        step(); rob_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq(32'h580 + 32'(i), 2'd1);
            step();
        end
        idle(); #2;
        reset = 1'b1; exp_q.delete(); #1;
        check("t6_valid", 128'(disp_valid), 128'(0));
        check("t6_fire", 128'(disp_fire), 128'(0));
        check("t6_rs_sel", 128'(disp_rs_sel), 128'(0));
        check("t6_ready", 128'(enq_ready), 128'(1));
`ifdef DISPATCH_STATS_EN
        check("t6_stall", 128'(stall_cycles), 128'(0));
`endif
        step(); reset = 1'b0; rob_full = 1'b0;
        step(); enq(32'h600, 2'd3);
        step(); idle(); #3;
        check("t6_head_payload", 128'(disp_payload), 128'(mk(32'h600)));
        check("t6_head_sel", 128'(disp_rs_sel), 128'(4'b1000));

        step(); step(); #3;
        check("all_issued", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Decoupling FIFO between the decode stage (instruction fields plus the info-decoder control bundle) and the four reservation stations. It buffers decoded instructions in program order and issues the head entry to its reservation station (00 ALU, 01 load/store, 10 branch/JAL/JALR, 11 LUI/AUIPC). Issue happens only when that station and the ROB can accept it. A branch-misprediction flush empties the queue in one cycle.

## Interface
- DEPTH, 8: entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous squash of every queued entry.
- enq_valid  in  1  decode presents an instruction.
- enq_ready  out  1  queue can accept; equals (count != DEPTH).
- enq_payload  in  93  {pc[31:0], imm[31:0], rs1[4:0], rs2[4:0], rd[4:0], funct3[2:0], ctrl[10:0]}. ctrl = {aluOp[1:0], memWrite, branch, isJAL, useImm, writeRegStatus, regWrite, isLUI, isAUIPC, isJALR}.
- enq_rs_station  in  2  target reservation station.
- rs_full  in  4  per-station full flags; bit n corresponds to station n.
- rob_full  in  1  ROB has no free entry.
- disp_valid  out  1  head entry valid (count != 0).
- disp_fire  out  1  head issued this cycle.
- disp_rs_sel  out  4  one-hot write enable to the stations; nonzero only when disp_fire.
- disp_payload  out  93  head payload, same layout as enq_payload.
- disp_rs_station  out  2  head station code.
- stall_cycles  out  32  only with DISPATCH_STATS_EN; otherwise the port is absent.

## Operation
- Storage: DEPTH-entry array of {payload, station}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Enqueue: enq_valid && enq_ready && !flush. Writes the entry at wptr, then wptr+1.
- Dispatch: disp_fire = disp_valid && !rs_full[disp_rs_station] && !rob_full && !flush. On fire, rptr advances by 1.
- disp_rs_sel = disp_fire ? (4'b1 << disp_rs_station) : 0.
- count next value is count + enq − fire. Simultaneous enqueue and dispatch leaves count unchanged.
- enq_ready ignores a same-cycle dispatch. When full, nothing enqueues, even if the head fires in that cycle.
- Flush has priority over everything. It sets rptr, wptr and count to 0. An enqueue in the flush cycle is dropped, and disp_fire is 0 in that cycle.
- A blocked head does not block entries behind it from enqueueing. Issue is strictly in order; there is no bypass of the head.
- The payload passes through unmodified. The block does not interpret ctrl.

## Timing
- Reset values:
  - rptr = wptr = count = 0
  - disp_valid = 0, disp_fire = 0, disp_rs_sel = 0
  - enq_ready = 1
  - stall_cycles = 0
  - disp_payload and disp_rs_station are don't-care while disp_valid = 0
- Latency: an entry enqueued at edge N is visible at the head from cycle N+1, and can fire in N+1 at the earliest.
- Throughput: one enqueue and one dispatch per cycle.
- disp_fire and disp_rs_sel are combinational from head state, rs_full, rob_full and flush. The stations sample on the same edge that advances rptr.
- Reset asserted mid-operation discards every entry immediately; there is no drain.
- Flush takes effect at the next edge. disp_valid = 0 in the following cycle.

## Configuration
- DISPATCH_STATS_EN defined: adds the 32-bit stall_cycles counter. It increments, saturating at 0xFFFF_FFFF, each cycle with disp_valid && !disp_fire && !flush. It clears on reset only, not on flush.
- DISPATCH_STATS_EN undefined: no counter and no stall_cycles port. All other behaviour is identical.

## Test plan
- Reset, then enqueue pc 0x100 with station 00, all full flags low. Required: disp_valid next cycle, disp_fire, disp_rs_sel = 0001, disp_payload matches.
- Fill 8 entries while rob_full = 1. Required: enq_ready = 0 after the 8th. A 9th enq_valid is ignored. Release rob_full: entries drain in order over 8 cycles.
- Head station 10 with rs_full = 0100. Required: disp_fire = 0 and the head holds. With DISPATCH_STATS_EN, stall_cycles counts 5 over 5 cycles. Clearing rs_full[2] fires with disp_rs_sel = 0100.
- Count = 3 with simultaneous enqueue and dispatch for 10 cycles. Required: count stays 3, and the pointers wrap past 7 with order preserved.
- Count = 5 with flush and enq_valid together. Required: next cycle count = 0, disp_valid = 0, enq_ready = 1, disp_fire = 0 during the flush cycle.
- Assert reset asynchronously mid-cycle with count = 4. Required: outputs reach reset values immediately. After release, the first enqueue appears at the head.
